sd_cmd_host: RTL

Host-side SD command-line engine inside the SoC.
- Generates sd_clk from the system clock.
- Serialises one 48-bit command frame onto sd_cmd, then waits for the card response, captures it and checks it.
- Sits directly upstream of the SD card, or of the sd_fake emulator in simulation, on the sd_clk/sd_cmd pair.
- Driven by a CPU-side register block through a start/done handshake.

---
 rtl/sd_cmd_host.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_host.sv
// Host-side SD command engine. It divides clk down to sd_clk, sends one 48-bit command frame,
// then captures and checks the card response. Define SD_CMD_HOST_CLK_STOP_EN to gate sd_clk in idle.
module sd_cmd_host #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned TIMEOUT_SDCLK = 64,
  parameter int unsigned NCC_SDCLK     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   cmd_idx,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic [5:0]   resp_idx,
  output logic [127:0] resp_data,
  output logic         timeout,
  output logic         crc_err,
  output logic         sd_clk,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_i
);

  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntMax = (TIMEOUT_SDCLK > 136) ? TIMEOUT_SDCLK : 136;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [1:0] RespNone = 2'b00;
  localparam logic [1:0] RespCrc  = 2'b01;
  localparam logic [1:0] RespR2   = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StTx,
    StWaitStart,
    StRx,
    StNcc,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              sd_clk_q, sd_clk_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [39:0]       tx_sr_q, tx_sr_d;
  logic [6:0]        crc_q, crc_d;
  logic [1:0]        rtype_q, rtype_d;
  logic              cmd_o_q, cmd_o_d;
  logic              cmd_oe_q, cmd_oe_d;
  logic [126:0]      rx_sr_q, rx_sr_d;
  logic [5:0]        resp_idx_q, resp_idx_d;
  logic [127:0]      resp_data_q, resp_data_d;
  logic              timeout_q, timeout_d;
  logic              crc_err_q, crc_err_d;

  logic              clk_run, wrap, rise, fall;
  logic [127:0]      rx_sh;
  logic [CntW-1:0]   rx_last;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], fb} ^ {3'b000, fb, 3'b000};
  endfunction

  always_comb begin
`ifdef SD_CMD_HOST_CLK_STOP_EN
    clk_run = (state_q != StIdle);
`else
    clk_run = 1'b1;
`endif
    wrap = (div_q == DivW'(CLK_DIV - 1));
    div_d = '0;
    sd_clk_d = 1'b0;
    if (clk_run) begin
      div_d    = wrap ? '0 : div_q + DivW'(1);
      sd_clk_d = wrap ? ~sd_clk_q : sd_clk_q;
    end
    rise = clk_run && wrap && !sd_clk_q;
    fall = clk_run && wrap && sd_clk_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    crc_d       = crc_q;
    rtype_d     = rtype_q;
    cmd_o_d     = cmd_o_q;
    cmd_oe_d    = cmd_oe_q;
    rx_sr_d     = rx_sr_q;
    resp_idx_d  = resp_idx_q;
    resp_data_d = resp_data_q;
    timeout_d   = timeout_q;
    crc_err_d   = crc_err_q;
    rx_sh       = {rx_sr_q, sd_cmd_i};
    rx_last     = (rtype_q == RespR2) ? CntW'(135) : CntW'(47);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StTx;
          tx_sr_d     = {2'b01, cmd_idx, cmd_arg};
          rtype_d     = resp_type;
          crc_d       = '0;
          cnt_d       = '0;
          timeout_d   = 1'b0;
          crc_err_d   = 1'b0;
          resp_idx_d  = '0;
          resp_data_d = '0;
        end
      end
      StTx: begin
        if (fall) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q < CntW'(40)) begin
            cmd_oe_d = 1'b1;
            cmd_o_d  = tx_sr_q[39];
            tx_sr_d  = {tx_sr_q[38:0], 1'b0};
            crc_d    = crc7_step(crc_q, tx_sr_q[39]);
          end else if (cnt_q < CntW'(47)) begin
            cmd_o_d = crc_q[6];
            crc_d   = {crc_q[5:0], 1'b0};
          end else if (cnt_q == CntW'(47)) begin
            cmd_o_d = 1'b1;
          end else begin
            // Release the line one full sd_clk after the end bit.
            cmd_oe_d = 1'b0;
            cmd_o_d  = 1'b1;
            cnt_d    = '0;
            state_d  = (rtype_q == RespNone) ? StNcc : StWaitStart;
          end
        end
      end
      StWaitStart: begin
        if (rise) begin
          if (!sd_cmd_i) begin
            // Start bit counts as the first received bit; a cleared shifter holds it.
            state_d = StRx;
            cnt_d   = CntW'(1);
            crc_d   = '0;
            rx_sr_d = '0;
          end else if (cnt_q == CntW'(TIMEOUT_SDCLK - 1)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = StNcc;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRx: begin
        if (rise) begin
          rx_sr_d = rx_sh[126:0];
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q < CntW'(40)) begin
            crc_d = crc7_step(crc_q, sd_cmd_i);
          end
          if (cnt_q == rx_last) begin
            cnt_d   = '0;
            state_d = StNcc;
            if (rtype_q == RespR2) begin
              resp_idx_d  = '0;
              resp_data_d = rx_sh;
              crc_err_d   = ~rx_sh[0];
            end else begin
              resp_idx_d  = rx_sh[45:40];
              resp_data_d = {96'b0, rx_sh[39:8]};
              crc_err_d   = ~rx_sh[0] | ((rtype_q == RespCrc) && (crc_q != rx_sh[7:1]));
            end
          end
        end
      end
      StNcc: begin
        if (rise) begin
          if (cnt_q == CntW'(NCC_SDCLK - 1)) begin
            cnt_d   = '0;
            state_d = StFin;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      sd_clk_q    <= 1'b0;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      crc_q       <= '0;
      rtype_q     <= RespNone;
      cmd_o_q     <= 1'b1;
      cmd_oe_q    <= 1'b0;
      rx_sr_q     <= '0;
      resp_idx_q  <= '0;
      resp_data_q <= '0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sd_clk_q    <= sd_clk_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      crc_q       <= crc_d;
      rtype_q     <= rtype_d;
      cmd_o_q     <= cmd_o_d;
      cmd_oe_q    <= cmd_oe_d;
      rx_sr_q     <= rx_sr_d;
      resp_idx_q  <= resp_idx_d;
      resp_data_q <= resp_data_d;
      timeout_q   <= timeout_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StFin);
  assign done      = (state_q == StFin);
  assign resp_idx  = resp_idx_q;
  assign resp_data = resp_data_q;
  assign timeout   = timeout_q;
  assign crc_err   = crc_err_q;
  assign sd_clk    = sd_clk_q;
  assign sd_cmd_o  = cmd_o_q;
  assign sd_cmd_oe = cmd_oe_q;

endmodule
